wb_cmd_master: RTL
==================

// Module: wb_cmd_master
// PURPOSE
//  Wishbone B4 classic-cycle initiator that drives the SDRAM controller's wb_* slave port.
//  Accepts one command at a time (read/write) on a valid/ready port and runs one
//  single-beat cycle. Returns read data or a timeout error on a valid/ready response port.
//  Sits between the stimulus generator and the DUV; it is the master side of the slave the bus checks monitor.
// PARAMETERS
//  AW       26   address width (wb_adr_o, cmd_addr)
//  DW       32   data width
//  SW       4    byte-select width (DW/8)
//  TMO_W    8    timeout counter width
//  TIMEOUT  200  max cycles waiting for ack; 0 = timeout disabled
// PORTS
//  wb_clk_i     in   1    bus clock; all logic on rising edge
//  wb_resetn    in   1    asynchronous active-low reset
//  cmd_valid    in   1    command present
//  cmd_ready    out  1    command accepted when valid&ready
//  cmd_we       in   1    1 = write, 0 = read
//  cmd_addr     in   AW   byte address
//  cmd_wdata    in   DW   write data
//  cmd_sel      in   SW   byte selects
//  rsp_valid    out  1    response present
//  rsp_ready    in   1    response consumed when valid&ready
//  rsp_rdata    out  DW   read data (0 for writes / errors)
//  rsp_we       out  1    echo of cmd_we
//  rsp_err      out  1    1 = ack timeout
//  wb_cyc_o     out  1    bus cycle
//  wb_stb_o     out  1    strobe
//  wb_we_o      out  1    write enable
//  wb_adr_o     out  AW   address
//  wb_dat_o     out  DW   write data
//  wb_sel_o     out  SW   byte selects
//  wb_dat_i     in   DW   read data from slave
//  wb_ack_i     in   1    slave acknowledge
//  txn_cnt      out  16   completed transactions (ack or timeout), wraps 0xFFFF->0
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE; every output 0; cmd_ready 0 during reset.
//  FSM: IDLE -> BUS -> RESP -> IDLE.
//   IDLE: cmd_ready=1. On cmd_valid&cmd_ready latch cmd_*; next cycle BUS.
//   BUS: wb_cyc_o=wb_stb_o=1, wb_we/adr/dat/sel = latched values, held stable until exit.
//        cyc and stb always rise and fall in the same cycle.
//        On wb_ack_i=1 at edge: capture wb_dat_i (if read, else 0); rsp_err=0; go RESP.
//        Timeout: tmo counter clears on BUS entry, +1 per BUS cycle without ack.
//        When count==TIMEOUT-1 and no ack: go RESP, rsp_err=1, rsp_rdata=0.
//        Ack on the same cycle as the timeout limit: ack wins, rsp_err=0.
//   RESP: cyc/stb=0 (falls the cycle after ack); rsp_valid=1, rsp_* stable until rsp_ready.
//         On rsp_valid&rsp_ready -> IDLE. Guaranteed >=1 idle bus cycle between cycles.
//  Latency: accept at edge N -> cyc/stb high N+1; ack sampled edge M -> cyc/stb low and
//   rsp_valid high from M+1. Zero-wait slave (ack at first BUS edge) gives accept-to-rsp 2 cycles.
//  cmd_ready is 0 outside IDLE: one outstanding command; no pipelining.
//  wb_ack_i outside BUS is ignored (no state change, no count).
//  txn_cnt increments by 1 on each BUS->RESP transition.
//  wb_we/adr/dat/sel are driven 0 when not in BUS.
//  Reset mid-cycle: cyc/stb drop immediately (async); the latched command is discarded; no response.
// TESTING
//  T1 write: cmd we=1 addr=0x0000040 wdata=0xDEADBEEF sel=0xF, slave acks 3rd BUS cycle ->
//     cyc/stb high exactly 3 cycles, dat_o stable, rsp_valid we=1 err=0 rdata=0, txn_cnt=1.
//  T2 read: cmd we=0 addr=0x0000040, slave returns 0xDEADBEEF with ack on 1st BUS cycle ->
//     rsp_rdata=0xDEADBEEF 2 cycles after accept; cyc/stb low the following cycle.
//  T3 timeout: TIMEOUT=200, slave never acks -> cyc/stb high exactly 200 cycles,
//     rsp_err=1, rdata=0; a late ack afterwards is ignored, txn_cnt +1 only.
//  T4 backpressure: rsp_ready=0 for 10 cycles after a read -> rsp_* held stable,
//     cmd_ready=0, no new cyc; a second queued cmd starts 2 cycles after rsp handshake.
//  T5 reset mid-BUS: deassert wb_resetn in BUS cycle 2 -> all outputs 0 same cycle,
//     no rsp_valid after release, txn_cnt=0.
//  T6 wrap: preload 0xFFFF transactions (or force counter) -> next completion gives txn_cnt=0.

Source files
------------

// File: rtl/wb_cmd_master_if.sv
// Command, response and Wishbone classic signals shared by wb_cmd_master and its environment.
// The master modport is the initiator's view; the slave modport is the stimulus/bus-slave side.
interface wb_cmd_master_if #(
  parameter int AW = 26,
  parameter int DW = 32,
  parameter int SW = 4
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_sel;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_we;
  logic          rsp_err;

  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic          wb_we_o;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o;
  logic [SW-1:0] wb_sel_o;
  logic [DW-1:0] wb_dat_i;
  logic          wb_ack_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_sel,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_we, rsp_err,
    input  rsp_ready,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_sel,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_we, rsp_err,
    output rsp_ready,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/wb_cmd_master.sv
// Single-outstanding Wishbone B4 classic initiator: one command in, one single-beat bus
// cycle out, one response back (read data or ack-timeout error), plus a completion counter.
module wb_cmd_master #(
  parameter int AW      = 26,
  parameter int DW      = 32,
  parameter int SW      = 4,
  parameter int TMO_W   = 8,
  parameter int TIMEOUT = 200
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_resetn,
  wb_cmd_master_if.master      bus,
  output logic [15:0]          txn_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic [TMO_W-1:0] TMO_LAST = (TIMEOUT == 0) ? '0 : TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

  state_e          state_q, state_d;
  logic            we_q, we_d;
  logic [AW-1:0]   adr_q, adr_d;
  logic [DW-1:0]   dat_q, dat_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [15:0]     txn_q, txn_d;

  logic in_bus;
  logic in_resp;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the latched command is reset too, so a reset mid-cycle cannot leak a stale command.
  always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
    if (!wb_resetn) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      tmo_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      txn_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      tmo_q   <= tmo_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      txn_q   <= txn_d;
    end
  end

  // NOTE: every _d gets its hold value first, so no path through the case can infer a latch.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    tmo_d   = tmo_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    txn_d   = txn_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          we_d    = bus.cmd_we;
          adr_d   = bus.cmd_addr;
          dat_d   = bus.cmd_wdata;
          sel_d   = bus.cmd_sel;
          tmo_d   = '0;
          state_d = S_BUS;
        end
      end
      S_BUS: begin
        // Ack is tested first so it wins over a timeout expiring on the same edge.
        if (bus.wb_ack_i) begin
          rdata_d = we_q ? '0 : bus.wb_dat_i;
          err_d   = 1'b0;
          txn_d   = txn_q + 16'd1;
          state_d = S_RESP;
        end else if ((TIMEOUT != 0) && (tmo_q == TMO_LAST)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          txn_d   = txn_q + 16'd1;
          state_d = S_RESP;
        end else if (TIMEOUT != 0) begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_bus  = (state_q == S_BUS);
  assign in_resp = (state_q == S_RESP);

  // Gated by reset so the command port reads not-ready while reset is held.
  assign bus.cmd_ready = (state_q == S_IDLE) && wb_resetn;

  assign bus.wb_cyc_o = in_bus;
  assign bus.wb_stb_o = in_bus;
  assign bus.wb_we_o  = in_bus & we_q;
  assign bus.wb_adr_o = in_bus ? adr_q : '0;
  assign bus.wb_dat_o = in_bus ? dat_q : '0;
  assign bus.wb_sel_o = in_bus ? sel_q : '0;

  assign bus.rsp_valid = in_resp;
  assign bus.rsp_rdata = in_resp ? rdata_q : '0;
  assign bus.rsp_we    = in_resp & we_q;
  assign bus.rsp_err   = in_resp & err_q;

  assign txn_cnt = txn_q;

endmodule
